// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - register file with combinational read ports and a debug dump FSM
// Build option: define REGFILE_BYPASS_EN for write-through forwarding on the read ports.
module regfile_wb #(
    parameter int NREG = 4,
    parameter int AW   = 2,
    parameter int DW   = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          RegWrite,
    input  logic [AW-1:0] WriteAddr,
    input  logic [DW-1:0] WriteData,
    input  logic [AW-1:0] ReadAddr1,
    input  logic [AW-1:0] ReadAddr2,
    output logic [DW-1:0] ReadData1,
    output logic [DW-1:0] ReadData2,
    input  logic          DumpStart,
    output logic          DumpValid,
    output logic [AW-1:0] DumpIdx,
    output logic [DW-1:0] DumpData,
    output logic          DumpDone,
    output logic          DumpBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    logic [DW-1:0] regs [NREG];
    state_t        state;
    logic [AW-1:0] cnt;
    logic          wr_en;

    assign wr_en = RegWrite && (WriteAddr != '0);

    // R0 is never written, so it holds its reset value of zero.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[WriteAddr] <= WriteData;
        end
    end

    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
        logic [DW-1:0] val;
        val = '0;
        if (addr != '0) begin
            val = regs[addr];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (addr == WriteAddr)) begin
            val = WriteData;
        end
`endif
        return val;
    endfunction

    always_comb begin
        ReadData1 = read_port(ReadAddr1);
        ReadData2 = read_port(ReadAddr2);
    end

    // Dump words sample regs before any write landing on the same edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            DumpValid <= 1'b0;
            DumpIdx   <= '0;
            DumpData  <= '0;
            DumpDone  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DumpValid <= 1'b0;
                    DumpDone  <= 1'b0;
                    cnt       <= '0;
                    if (DumpStart) begin
                        state <= DUMP;
                    end
                end
                DUMP: begin
                    DumpValid <= 1'b1;
                    DumpIdx   <= cnt;
                    DumpData  <= regs[cnt];
                    if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    DumpValid <= 1'b0;
                    DumpDone  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign DumpBusy = (state != IDLE);

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Register file with debug dump for the 16-bit single-cycle datapath. Sits directly downstream of the 3-to-1 write-back multiplexer: that mux's 16-bit output is written here on the rising clock edge, and this block's two read ports feed the ALU operand path. A small state machine streams every register out on a debug port, one per cycle, so benches can check architectural state without hierarchical references.

## Interface
- `NREG`, default 4: number of registers; must be a power of two, at least 2.
- `AW`, default 2: register address width; must equal log2(NREG).
- `DW`, default 16: data width.

Ports:
- `Clock`, in, 1: single clock; all state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset, sampled on the rising edge of `Clock`.
- `RegWrite`, in, 1: write enable from the control unit.
- `WriteAddr`, in, AW: destination register.
- `WriteData`, in, DW: write-back value from the 3-to-1 mux output.
- `ReadAddr1`, in, AW: operand A address.
- `ReadAddr2`, in, AW: operand B address.
- `ReadData1`, out, DW: operand A (combinational).
- `ReadData2`, out, DW: operand B (combinational).
- `DumpStart`, in, 1: request a full register dump.
- `DumpValid`, out, 1: dump word valid this cycle.
- `DumpIdx`, out, AW: index of the dumped register.
- `DumpData`, out, DW: dumped register value.
- `DumpDone`, out, 1: one-cycle pulse in the cycle after the last dump word.
- `DumpBusy`, out, 1: high while the FSM is not IDLE.

## Operation
- Storage: NREG x DW flops; R0 always reads 0 and ignores writes.
- Write: if `RegWrite`=1 and `WriteAddr`!=0, reg[`WriteAddr`] <= `WriteData` at the clock edge.
- Read: `ReadDataN` = reg[`ReadAddrN`] combinationally; address 0 gives 0.
- Both read ports can address the same register as each other or as the write port with no restriction.
- Dump FSM states:
  - IDLE -> DUMP when `DumpStart`=1.
  - DUMP: `DumpValid`=1, `DumpIdx`=counter, `DumpData`=registered value of reg[counter], taken before any write at the same edge. Counter increments each cycle. After index NREG-1, DUMP -> DONE.
  - DONE: `DumpDone`=1 for one cycle, then -> IDLE.
- `DumpStart` is ignored while `DumpBusy`=1.
- Writes continue normally during a dump. A register written after its dump cycle is not re-dumped.
- Counter wraps only through the IDLE reset of the counter; it never exceeds NREG-1.

## Timing
- Reset (synchronous): all registers 0; FSM IDLE; counter 0. `DumpValid`, `DumpDone`, `DumpBusy` = 0; `DumpIdx` = 0; `DumpData` = 0.
- Reset asserted mid-dump aborts the dump with no `DumpDone` pulse. Reset takes priority over `RegWrite` and `DumpStart` in the same cycle.
- Write latency: 1 edge. Read latency: 0 (combinational).
- Dump: `DumpStart` sampled at edge k gives words at edges k+1..k+NREG, with `DumpValid` high for exactly NREG cycles and `DumpDone` high during cycle k+NREG+1. `DumpStart` is accepted again from that DONE cycle's edge onward, i.e. the earliest restart is sampled when the FSM is in IDLE.

## Configuration
- `REGFILE_BYPASS_EN` defined: when `RegWrite`=1, `WriteAddr`!=0 and `ReadAddrN`==`WriteAddr`, `ReadDataN` returns `WriteData` in the same cycle (write-through forwarding).
- Not defined: `ReadDataN` returns the old stored value until after the edge.
- The dump path is unaffected by the macro in both cases.

## Test plan
- Reset: assert `Reset` 1 cycle after arbitrary writes -> all reads 0, `DumpBusy`=0, `DumpValid`=0.
- Write/read: write 16'd5 to R1, 16'd20 to R2, 16'd23 to R3; read (1,3) -> 5, 23. Write 16'hFFFF to R0 -> R0 still reads 0.
- Bypass: R2=20; same cycle `RegWrite`=1, `WriteAddr`=2, `WriteData`=99, `ReadAddr1`=2 -> 99 with `REGFILE_BYPASS_EN`, 20 without. Both builds read 99 next cycle.
- Dump: R1..R3 = 5, 20, 23; pulse `DumpStart` -> `DumpValid` for 4 cycles with (idx, data) = (0,0), (1,5), (2,20), (3,23). Then `DumpDone` is high for 1 cycle; a `DumpStart` held during the dump starts no second dump until IDLE.
- Write during dump: write 77 to R1 in the cycle idx=1 is dumped -> dump shows 5; a later read of R1 gives 77.
- Reset mid-dump: assert `Reset` at idx=2 -> no `DumpDone`, `DumpBusy`=0 next cycle, all registers 0.
